// File: rtl/ldpc_enc_if.sv
// Information-block input handshake and codeword output bundle of the LDPC encoder.
interface ldpc_enc_if #(
  parameter int R = 24,
  parameter int D = 96
);
  logic           in_valid;
  logic [D-1:0]   in_data;
  logic           in_ready;
  logic           out_valid;
  logic [R*D-1:0] cw;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  cw
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output cw
  );
endinterface

// File: rtl/ldpc_enc.sv
// Systematic QC-LDPC encoder: accumulates R-C info blocks, then solves the dual-diagonal parity.
// out_valid pulses C cycles after the last accepted block; in_ready is low outside accumulation.
module ldpc_enc #(
  parameter int mtx_w = 8,
  parameter int R     = 24,
  parameter int C     = 12,
  parameter int D     = 96
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [C*R*mtx_w-1:0] mtx,
  ldpc_enc_if.slave            bus
);
  localparam int K       = R - C;
  localparam int CNT_MAX = (K > C) ? K : C;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {ACC, P0, PAR, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [D-1:0]     lambda     [C];
  logic [D-1:0]     lambda_nxt [C];
  logic [R*D-1:0]   cw, cw_nxt;
  logic             out_valid, out_valid_nxt;
  logic             in_ready, take;
  logic [mtx_w-1:0] col_s [C];
  logic [mtx_w-1:0] par_s;
  logic [D-1:0]     p0, prev, lam_sel, par;

  // Same convention as the decoder: y[k] = x[(k+s) mod D], out-of-range shift is a null block.
  function automatic logic [D-1:0] cyc_shift(input logic [D-1:0] x, input logic [mtx_w-1:0] s);
    logic [2*D-1:0] xx;
    xx = {x, x} >> s;
    if (32'(s) >= 32'(D)) return '0;
    return xx[D-1:0];
  endfunction

  assign in_ready      = rst & en & (state == ACC);
  assign take          = in_ready & bus.in_valid;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.cw        = cw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACC;
      cnt       <= '0;
      cw        <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < C; i++) lambda[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cw        <= cw_nxt;
      out_valid <= out_valid_nxt;
      for (int i = 0; i < C; i++) lambda[i] <= lambda_nxt[i];
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cw_nxt        = cw;
    out_valid_nxt = out_valid;
    for (int i = 0; i < C; i++) begin
      lambda_nxt[i] = lambda[i];
      col_s[i]      = '0;
    end
    p0      = cw[K*D +: D];
    prev    = '0;
    lam_sel = '0;
    par_s   = '0;
    par     = '0;

    if (en) begin
      unique case (state)
        ACC: begin
          if (take) begin
            for (int j = 0; j < K; j++) begin
              if (int'(cnt) == j) begin
                cw_nxt[j*D +: D] = bus.in_data;
                for (int i = 0; i < C; i++) col_s[i] = mtx[(i*R + j)*mtx_w +: mtx_w];
              end
            end
            for (int i = 0; i < C; i++) lambda_nxt[i] = lambda[i] ^ cyc_shift(bus.in_data, col_s[i]);
            if (int'(cnt) == K - 1) begin
              cnt_nxt   = '0;
              state_nxt = P0;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
        end

        // Summing every row cancels the dual-diagonal, leaving p0 as the XOR of all row syndromes.
        P0: begin
          for (int i = 0; i < C; i++) par = par ^ lambda[i];
          cw_nxt[K*D +: D] = par;
          cnt_nxt          = CNT_W'(1);
          state_nxt        = PAR;
        end

        PAR: begin
          for (int k = 1; k < C; k++) begin
            if (int'(cnt) == k) begin
              prev    = (k == 1) ? '0 : cw[(K + k - 1)*D +: D];
              lam_sel = lambda[k-1];
              par_s   = mtx[((k - 1)*R + K)*mtx_w +: mtx_w];
            end
          end
          par = prev ^ lam_sel ^ cyc_shift(p0, par_s);
          for (int k = 1; k < C; k++) begin
            if (int'(cnt) == k) cw_nxt[(K + k)*D +: D] = par;
          end
          if (int'(cnt) == C - 1) begin
            state_nxt     = DONE;
            out_valid_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        DONE: begin
          out_valid_nxt = 1'b0;
          cnt_nxt       = '0;
          for (int i = 0; i < C; i++) lambda_nxt[i] = '0;
          state_nxt     = ACC;
        end

        default: state_nxt = ACC;
      endcase
    end
  end
endmodule
